// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op-class codes, FSM state encodings
// and the memory-op classifier used by both the RTL and its bench.
package lsu_pkg;

   localparam logic [4:0] I_ADD = 5'h00;
   localparam logic [4:0] I_LW  = 5'h08;
   localparam logic [4:0] I_SW  = 5'h09;

   localparam int WAIT_W = 10;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_DONE = 2'd2
   } lsu_state_t;

   function automatic logic is_mem_op(input logic [4:0] op);
      return (op == I_LW) || (op == I_SW);
   endfunction

endpackage

// File: rtl/load_store_unit_agen.sv
// Effective-address generator: base + offset modulo 2^32 plus word-alignment check.
// Purely combinational; no backpressure.
module lsu_agen (
   input  logic [31:0] base,
   input  logic [31:0] offset,
   output logic [31:0] ea,
   output logic        misalign
);

   assign ea       = base + offset;
   assign misalign = |ea[1:0];

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one LW/SW request/ack transaction per start, done pulse on finish.
// Misaligned addresses and ack timeouts end the access with an error flag instead of stalling.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  op_type,
   input  logic [31:0] base,
   input  logic [31:0] offset,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        timeout
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

   lsu_state_t        state;
   lsu_state_t        state_next;
   logic [31:0]       ea;
   logic              misalign;
   logic [4:0]        op_q;
   logic [29:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              unused_ea_lsb;

   lsu_agen u_agen (
      .base     (base),
      .offset   (offset),
      .ea       (ea),
      .misalign (misalign)
   );

   assign unused_ea_lsb = ^ea[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LSU_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Ack is tested before the counter so an ack on the final wait cycle still succeeds.
   always_comb begin
      state_next = state;
      case (state)
         LSU_IDLE: begin
            if (start) begin
               if (!is_mem_op(op_type) || misalign) begin
                  state_next = LSU_DONE;
               end else begin
                  state_next = LSU_REQ;
               end
            end
         end
         LSU_REQ: begin
            if (mem_ack || (wait_cnt == WAIT_LAST)) begin
               state_next = LSU_DONE;
            end
         end
         LSU_DONE: state_next = LSU_IDLE;
         default:  state_next = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wait_cnt   <= '0;
         load_data  <= '0;
         misaligned <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         case (state)
            LSU_IDLE: begin
               if (start) begin
                  op_q       <= op_type;
                  addr_q     <= ea[31:2];
                  wdata_q    <= store_data;
                  wait_cnt   <= '0;
                  misaligned <= is_mem_op(op_type) && misalign;
                  timeout    <= 1'b0;
               end
            end
            LSU_REQ: begin
               if (mem_ack) begin
                  if (op_q == I_LW) begin
                     load_data <= mem_rdata;
                  end
               end else begin
                  if (wait_cnt == WAIT_LAST) begin
                     timeout <= 1'b1;
                  end
                  if (wait_cnt != WAIT_MAX) begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req   = (state == LSU_REQ);
   assign mem_we    = mem_req && (op_q == I_SW);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state != LSU_IDLE);
   assign done      = (state == LSU_DONE);

endmodule
